// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle between the ID/EX pipeline register and the forwarding/hazard controller.
// The master is the pipeline (drives the ID fields), the slave is the controller (drives selects and controls).
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // id_valid qualifies every id_* field in the same cycle; there is no ready,
  // backpressure is expressed through stall_if_id / bubble_ex instead.
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_we;
  logic [1:0]            id_wb_sel;
  logic                  id_asel_pc;
  logic                  id_bsel_imm;
  logic                  ex_br_taken;

  logic [1:0]            alu_a_sel;
  logic [1:0]            alu_b_sel;
  logic [1:0]            store_fwd_sel;
  logic                  stall_if_id;
  logic                  bubble_ex;
  logic                  flush_if_id;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  // Stage trackers {ex, mem, wb}, each {valid, rd, we, is_load}.
  logic [3*(REG_ADDR_W+3)-1:0] trk_dbg;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_we, id_wb_sel, id_asel_pc, id_bsel_imm, ex_br_taken,
    input  alu_a_sel, alu_b_sel, store_fwd_sel, stall_if_id, bubble_ex,
           flush_if_id, stall_cnt, flush_cnt, trk_dbg
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_we, id_wb_sel, id_asel_pc, id_bsel_imm, ex_br_taken,
    output alu_a_sel, alu_b_sel, store_fwd_sel, stall_if_id, bubble_ex,
           flush_if_id, stall_cnt, flush_cnt, trk_dbg
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects plus load-use stall and branch flush control.
// Selects are computed at decode and registered so they are valid when the instruction sits in EX.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  fwd_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] WB_DMEM  = 2'b00;
  localparam logic [1:0] SEL_REG  = 2'b00;
  localparam logic [1:0] SEL_ALT  = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_WB   = 2'b11;

  logic                  ex_valid, ex_we, ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  mem_valid, mem_we, mem_is_load;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_we, wb_is_load;
  logic [REG_ADDR_W-1:0] wb_rd;

  logic ex_match_rs1, ex_match_rs2, mem_match_rs1, mem_match_rs2;
  logic load_use, advance;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [1:0] a_next, b_next, s_next;

  // x0 never produces a forwardable value, so it is excluded from every match.
  assign ex_match_rs1  = ex_valid  && ex_we  && (ex_rd  == bus.id_rs1) && (bus.id_rs1 != '0) && bus.id_uses_rs1;
  assign ex_match_rs2  = ex_valid  && ex_we  && (ex_rd  == bus.id_rs2) && (bus.id_rs2 != '0) && bus.id_uses_rs2;
  assign mem_match_rs1 = mem_valid && mem_we && (mem_rd == bus.id_rs1) && (bus.id_rs1 != '0) && bus.id_uses_rs1;
  assign mem_match_rs2 = mem_valid && mem_we && (mem_rd == bus.id_rs2) && (bus.id_rs2 != '0) && bus.id_uses_rs2;

  assign load_use = bus.id_valid && ex_is_load && (ex_match_rs1 || ex_match_rs2);

  // A taken branch discards the ID instruction, so it overrides any load-use stall.
  assign bus.flush_if_id = bus.ex_br_taken;
  assign bus.stall_if_id = load_use && !bus.ex_br_taken;
  assign bus.bubble_ex   = load_use || bus.ex_br_taken;
  assign advance         = bus.id_valid && !bus.bubble_ex;

  // The youngest producer (EX) wins over MEM.
  assign fwd_rs1 = ex_match_rs1 ? SEL_MEM : (mem_match_rs1 ? SEL_WB : SEL_REG);
  assign fwd_rs2 = ex_match_rs2 ? SEL_MEM : (mem_match_rs2 ? SEL_WB : SEL_REG);

  always_comb begin
    a_next = SEL_REG;
    b_next = SEL_REG;
    s_next = SEL_REG;
    if (advance) begin
      a_next = bus.id_asel_pc  ? SEL_ALT : fwd_rs1;
      b_next = bus.id_bsel_imm ? SEL_ALT : fwd_rs2;
      s_next = fwd_rs2;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_we       <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_rd       <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_is_load <= 1'b0;
      mem_rd      <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_is_load  <= 1'b0;
      wb_rd       <= '0;
    end else begin
      wb_valid    <= mem_valid;
      wb_we       <= mem_we;
      wb_is_load  <= mem_is_load;
      wb_rd       <= mem_rd;
      mem_valid   <= ex_valid;
      mem_we      <= ex_we;
      mem_is_load <= ex_is_load;
      mem_rd      <= ex_rd;
      ex_valid    <= advance;
      ex_we       <= advance && bus.id_reg_we;
      ex_is_load  <= advance && bus.id_reg_we && (bus.id_wb_sel == WB_DMEM);
      ex_rd       <= advance ? bus.id_rd : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.alu_a_sel     <= SEL_REG;
      bus.alu_b_sel     <= SEL_REG;
      bus.store_fwd_sel <= SEL_REG;
    end else begin
      bus.alu_a_sel     <= a_next;
      bus.alu_b_sel     <= b_next;
      bus.store_fwd_sel <= s_next;
    end
  end

  // Performance counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (bus.stall_if_id && (bus.stall_cnt != '1))
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (bus.flush_if_id && (bus.flush_cnt != '1))
        bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
    end
  end

  assign bus.trk_dbg = {ex_valid,  ex_rd,  ex_we,  ex_is_load,
                        mem_valid, mem_rd, mem_we, mem_is_load,
                        wb_valid,  wb_rd,  wb_we,  wb_is_load};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, load-use stall, flush, x0, reset and saturation.
module tb_fwd_hazard_ctrl;

  localparam logic [1:0] WB_LOAD = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  sat_bus ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (sat_bus)
  );

  assign sat_bus.id_valid    = bus.id_valid;
  assign sat_bus.id_rs1      = bus.id_rs1;
  assign sat_bus.id_rs2      = bus.id_rs2;
  assign sat_bus.id_uses_rs1 = bus.id_uses_rs1;
  assign sat_bus.id_uses_rs2 = bus.id_uses_rs2;
  assign sat_bus.id_rd       = bus.id_rd;
  assign sat_bus.id_reg_we   = bus.id_reg_we;
  assign sat_bus.id_wb_sel   = bus.id_wb_sel;
  assign sat_bus.id_asel_pc  = bus.id_asel_pc;
  assign sat_bus.id_bsel_imm = bus.id_bsel_imm;
  assign sat_bus.ex_br_taken = bus.ex_br_taken;

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic [1:0] wbs,
                          input logic asel, input logic bsel);
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_rd       = rd;
    bus.id_reg_we   = we;
    bus.id_wb_sel   = wbs;
    bus.id_asel_pc  = asel;
    bus.id_bsel_imm = bsel;
    #1;
  endtask

  task automatic idle();
    bus.ex_br_taken = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WB_ALU, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  // Scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    repeat (2) step();
    n_cmp++;
    if ({bus.alu_a_sel, bus.alu_b_sel, bus.store_fwd_sel} !== 6'b0) begin
      $display("FAIL reset_sels got %b want 000000", {bus.alu_a_sel, bus.alu_b_sel, bus.store_fwd_sel});
      n_fail++;
    end
    n_cmp++;
    if ({bus.stall_if_id, bus.bubble_ex, bus.flush_if_id} !== 3'b000) begin
      $display("FAIL reset_ctrl got %b want 000", {bus.stall_if_id, bus.bubble_ex, bus.flush_if_id});
      n_fail++;
    end
    n_cmp++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
      n_fail++;
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fwd_ex();
    drain();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0);
    n_cmp++;
    if (bus.stall_if_id !== 1'b0) begin
      $display("FAIL fwd_ex_nostall got %b want 0", bus.stall_if_id);
      n_fail++;
    end
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b10 || bus.alu_b_sel !== 2'b00) begin
      $display("FAIL fwd_ex_sels got a=%b b=%b want a=10 b=00", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
  endtask

  task automatic test_fwd_mem();
    drain();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    idle();
    step();
    drive_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b00 || bus.alu_b_sel !== 2'b11) begin
      $display("FAIL fwd_mem_sels got a=%b b=%b want a=00 b=11", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
  endtask

  task automatic test_load_use();
    drain();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, WB_LOAD, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.stall_if_id, bus.bubble_ex, bus.flush_if_id} !== 3'b110) begin
      $display("FAIL lu_ctrl got %b want 110", {bus.stall_if_id, bus.bubble_ex, bus.flush_if_id});
      n_fail++;
    end
    step();
    n_cmp++;
    if ({bus.stall_if_id, bus.bubble_ex} !== 2'b00) begin
      $display("FAIL lu_one_cycle got %b want 00", {bus.stall_if_id, bus.bubble_ex});
      n_fail++;
    end
    n_cmp++;
    if (bus.alu_a_sel !== 2'b00 || bus.alu_b_sel !== 2'b00) begin
      $display("FAIL lu_bubble_sels got a=%b b=%b want 00 00", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b11 || bus.alu_b_sel !== 2'b11) begin
      $display("FAIL lu_fwd_sels got a=%b b=%b want 11 11", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
    n_cmp++;
    if (bus.stall_cnt !== 32'd1) begin
      $display("FAIL lu_stall_cnt got %0d want 1", bus.stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_x0_and_imm();
    drain();
    drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, WB_LOAD, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, WB_ALU, 1'b0, 1'b0);
    n_cmp++;
    if (bus.stall_if_id !== 1'b0 || bus.bubble_ex !== 1'b0) begin
      $display("FAIL x0_nostall got %b%b want 00", bus.stall_if_id, bus.bubble_ex);
      n_fail++;
    end
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b00 || bus.alu_b_sel !== 2'b00) begin
      $display("FAIL x0_sels got a=%b b=%b want 00 00", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
    drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b0, WB_ALU, 1'b1, 1'b1);
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b01 || bus.alu_b_sel !== 2'b01 || bus.store_fwd_sel !== 2'b10) begin
      $display("FAIL pc_imm_sels got a=%b b=%b s=%b want 01 01 10",
               bus.alu_a_sel, bus.alu_b_sel, bus.store_fwd_sel);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    drain();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, WB_LOAD, 1'b0, 1'b0);
    step();
    bus.ex_br_taken = 1'b1;
    drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.stall_if_id, bus.bubble_ex, bus.flush_if_id} !== 3'b011) begin
      $display("FAIL flush_ctrl got %b want 011", {bus.stall_if_id, bus.bubble_ex, bus.flush_if_id});
      n_fail++;
    end
    step();
    idle();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b00) begin
      $display("FAIL flush_sel got %b want 00", bus.alu_a_sel);
      n_fail++;
    end
    n_cmp++;
    if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd1) begin
      $display("FAIL flush_cnts got f=%0d s=%0d want f=1 s=1", bus.flush_cnt, bus.stall_cnt);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, WB_LOAD, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0);
    n_cmp++;
    if (bus.stall_if_id !== 1'b1) begin
      $display("FAIL rst_pre_stall got %b want 1", bus.stall_if_id);
      n_fail++;
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stall_if_id, bus.bubble_ex, bus.flush_if_id,
         bus.alu_a_sel, bus.alu_b_sel, bus.store_fwd_sel} !== 9'b0) begin
      $display("FAIL rst_async_outs got %b want 0", {bus.stall_if_id, bus.bubble_ex,
               bus.flush_if_id, bus.alu_a_sel, bus.alu_b_sel, bus.store_fwd_sel});
      n_fail++;
    end
    n_cmp++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      $display("FAIL rst_async_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
      n_fail++;
    end
    idle();
    step();
    reset_n = 1'b1;
    drive_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, WB_ALU, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (bus.alu_a_sel !== 2'b00 || bus.alu_b_sel !== 2'b00) begin
      $display("FAIL rst_no_residual got a=%b b=%b want 00 00", bus.alu_a_sel, bus.alu_b_sel);
      n_fail++;
    end
  endtask

  task automatic test_saturation();
    drain();
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, WB_LOAD, 1'b0, 1'b0);
      step();
      drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, WB_ALU, 1'b0, 1'b0);
      step();
      step();
      if (i >= 2) begin
        n_cmp++;
        if (sat_bus.stall_cnt !== 2'b11) begin
          $display("FAIL sat_stall_cnt iter %0d got %0d want 3", i, sat_bus.stall_cnt);
          n_fail++;
        end
      end
    end
    n_cmp++;
    if (bus.stall_cnt !== 32'd4) begin
      $display("FAIL wide_stall_cnt got %0d want 4", bus.stall_cnt);
      n_fail++;
    end
    idle();
    bus.ex_br_taken = 1'b1;
    repeat (5) step();
    bus.ex_br_taken = 1'b0;
    n_cmp++;
    if (sat_bus.flush_cnt !== 2'b11 || bus.flush_cnt !== 32'd5) begin
      $display("FAIL sat_flush_cnt got sat=%0d wide=%0d want 3 5", sat_bus.flush_cnt, bus.flush_cnt);
      n_fail++;
    end
  endtask

  // Sequence and final report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_x0_and_imm();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
